clint_timer: RTL and testbench

Core-local interruptor (CLINT) timer/software-interrupt block: the device end of the CSR file's CLINT port. It holds `mtime`, `mtimecmp` and `msip` behind a single-outstanding MMIO slave, pushes `mtime` into the CSR file's `time` register on every tick, and drives `mip.MTIP`, `mip.STIP` (Sstc, from `stimecmp`/`menvcfg.STCE`) and `mip.MSIP`. It sits between the SoC MMIO crossbar and the hart's CSR register file.

---
 rtl/clint_timer.sv | 164 ++++++++++++++++
 tb/tb_clint_timer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor timer and software-interrupt block.
//
// Holds mtime, mtimecmp and msip behind a single-outstanding MMIO slave.
// It pushes mtime into the CSR file's time register and drives the
// machine timer, supervisor timer (Sstc) and machine software pending bits.
//
// Ports
//   clock, reset                 clock; asynchronous active-high reset
//   req_valid/req_ready          MMIO request handshake
//   req_we, req_addr             1 = write; byte offset within the window
//   req_wdata, req_wstrb         write data and byte enables
//   resp_valid/resp_ready        response handshake (single-entry buffer)
//   resp_rdata, resp_err         read data (0 on writes/faults); access fault
//   time_w_en, time_w_data       strobe and value for the CSR time register
//   stimecmp_rdata               current stimecmp from the CSR file
//   menvcfg_rdata                current menvcfg (bit 63 = STCE)
//   mip_mtip, mip_stip, mip_msip registered interrupt-pending outputs
//
// Register map (8-byte aligned): 0x0000 msip, 0x4000 mtimecmp, 0xBFF8 mtime.
module clint_timer #(
    parameter int XLEN     = 64,
    parameter int TICK_DIV = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [15:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN/8-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              time_w_en,
    output logic [XLEN-1:0]   time_w_data,
    input  logic [XLEN-1:0]   stimecmp_rdata,
    input  logic [XLEN-1:0]   menvcfg_rdata,
    output logic              mip_mtip,
    output logic              mip_stip,
    output logic              mip_msip
);

    localparam int          NBYTES        = XLEN / 8;
    localparam logic [15:0] OFF_MSIP      = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP  = 16'h4000;
    localparam logic [15:0] OFF_MTIME     = 16'hBFF8;
    localparam logic [15:0] DIV_LAST      = 16'(TICK_DIV - 1);
    localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};

    // Byte-lane write merge: strobed lanes take new data, others keep old.
    function automatic logic [XLEN-1:0] merge_bytes(
        input logic [XLEN-1:0]   old_val,
        input logic [XLEN-1:0]   new_val,
        input logic [NBYTES-1:0] strb
    );
        logic [XLEN-1:0] res;
        res = old_val;
        for (int i = 0; i < NBYTES; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [XLEN-1:0] mtime;
    logic [XLEN-1:0] mtimecmp;
    logic            msip;
    logic [15:0]     div_cnt;

    logic            acc_p0;
    logic            tick_p0;
    logic            hit_msip_p0;
    logic            hit_cmp_p0;
    logic            hit_time_p0;
    logic            err_p0;
    logic            wr_p0;
    logic [XLEN-1:0] rdata_p0;
    logic [XLEN-1:0] mtime_nxt_p0;

    // Only STCE is consumed from menvcfg.
    logic envcfg_unused;
    assign envcfg_unused = ^menvcfg_rdata[XLEN-2:0];

    // ---- accept stage: decode, read sampling, next mtime ----
    assign req_ready   = !resp_valid || resp_ready;
    assign acc_p0      = req_valid && req_ready;
    assign tick_p0     = (div_cnt == DIV_LAST);
    assign hit_msip_p0 = (req_addr == OFF_MSIP);
    assign hit_cmp_p0  = (req_addr == OFF_MTIMECMP);
    assign hit_time_p0 = (req_addr == OFF_MTIME);
    // The valid offsets are all aligned, so misalignment falls out as a miss.
    assign err_p0      = !(hit_msip_p0 || hit_cmp_p0 || hit_time_p0);
    // A zero-strobe write touches nothing, not even the time push.
    assign wr_p0       = acc_p0 && req_we && !err_p0 && (|req_wstrb);

    always_comb begin
        rdata_p0 = '0;
        if (!req_we) begin
            if (hit_msip_p0) begin
                rdata_p0 = {{(XLEN-1){1'b0}}, msip};
            end else if (hit_cmp_p0) begin
                rdata_p0 = mtimecmp;
            end else if (hit_time_p0) begin
                rdata_p0 = mtime;
            end
        end

        mtime_nxt_p0 = tick_p0 ? (mtime + ONE) : mtime;
        // A software write beats a coincident tick: no increment that cycle.
        if (wr_p0 && hit_time_p0) begin
            mtime_nxt_p0 = merge_bytes(mtime, req_wdata, req_wstrb);
        end
    end

    // ---- register stage: state, response buffer, registered outputs ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            mtime       <= '0;
            mtimecmp    <= '1;
            msip        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            time_w_en   <= 1'b0;
            time_w_data <= '0;
            mip_mtip    <= 1'b0;
            mip_stip    <= 1'b0;
            mip_msip    <= 1'b0;
        end else begin
            // Prescaler free-runs; mtime writes do not realign it.
            div_cnt <= tick_p0 ? '0 : (div_cnt + 16'd1);
            mtime   <= mtime_nxt_p0;

            if (wr_p0 && hit_cmp_p0) begin
                mtimecmp <= merge_bytes(mtimecmp, req_wdata, req_wstrb);
            end
            if (wr_p0 && hit_msip_p0 && req_wstrb[0]) begin
                msip <= req_wdata[0];
            end

            time_w_en <= tick_p0 || (wr_p0 && hit_time_p0);
            if (tick_p0 || (wr_p0 && hit_time_p0)) begin
                time_w_data <= mtime_nxt_p0;
            end

            mip_mtip <= (mtime >= mtimecmp);
            mip_stip <= menvcfg_rdata[XLEN-1] && (mtime >= stimecmp_rdata);
            mip_msip <= msip;

            if (acc_p0) begin
                resp_valid <= 1'b1;
                resp_rdata <= err_p0 ? '0 : rdata_p0;
                resp_err   <= err_p0;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: randomized and directed checks of clint_timer against a
// cycle-stepped behavioural reference model.
`timescale 1ns/1ps
module tb_clint_timer;

    localparam int TD = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        time_w_en;
    logic [63:0] time_w_data;
    logic [63:0] stimecmp_rdata;
    logic [63:0] menvcfg_rdata;
    logic        mip_mtip;
    logic        mip_stip;
    logic        mip_msip;

    clint_timer #(.XLEN(64), .TICK_DIV(TD)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .time_w_en      (time_w_en),
        .time_w_data    (time_w_data),
        .stimecmp_rdata (stimecmp_rdata),
        .menvcfg_rdata  (menvcfg_rdata),
        .mip_mtip       (mip_mtip),
        .mip_stip       (mip_stip),
        .mip_msip       (mip_msip)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] m_mtime, m_cmp;
    logic        m_msip;
    int          m_cyc;        // edges since reset release; ticks are purely cycle-based
    logic        m_rv, m_err;
    logic [63:0] m_rdata;
    logic        m_twen;
    logic [63:0] m_twdata;
    logic        m_mtip, m_stip, m_msip_o;

    function automatic logic [63:0] apply_strobes(input logic [63:0] old_v, input logic [63:0] new_v,
                                                  input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int b = 0; b < 8; b++) if (strb[b]) mask = mask | (64'hFF << (8 * b));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic set_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 64'h0;
        req_wstrb = 8'h0;
    endtask

    task automatic model_reset();
        m_mtime = '0; m_cmp = '1; m_msip = 1'b0; m_cyc = 0;
        m_rv = 1'b0; m_err = 1'b0; m_rdata = '0; m_twen = 1'b0; m_twdata = '0;
        m_mtip = 1'b0; m_stip = 1'b0; m_msip_o = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_time_w_en", 64'(time_w_en), 64'd0);
        check("rst_time_w_data", time_w_data, 64'd0);
        check("rst_mip", {61'd0, mip_mtip, mip_stip, mip_msip}, 64'd0);
    endtask

    // Called just after an edge; asserts reset immediately (asynchronously).
    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs();
        model_reset();
        reset = 1'b0;
    endtask

    // One clock cycle: inputs are already applied; predict, clock, compare.
    task automatic step();
        logic        acc, tick, hs, hc, ht, bad, wr;
        logic [63:0] rd, nt;
        #1;
        check("req_ready", 64'(req_ready), 64'(!m_rv || resp_ready));
        acc  = req_valid && (!m_rv || resp_ready);
        tick = (m_cyc % TD) == TD - 1;
        hs   = req_addr == 16'h0000;
        hc   = req_addr == 16'h4000;
        ht   = req_addr == 16'hBFF8;
        bad  = !(hs || hc || ht);
        rd   = hs ? {63'd0, m_msip} : hc ? m_cmp : ht ? m_mtime : 64'd0;

        m_mtip   = m_mtime >= m_cmp;
        m_stip   = menvcfg_rdata[63] && (m_mtime >= stimecmp_rdata);
        m_msip_o = m_msip;

        nt     = tick ? m_mtime + 64'd1 : m_mtime;
        m_twen = tick;
        if (acc) begin
            m_rv    = 1'b1;
            m_err   = bad;
            m_rdata = (req_we || bad) ? 64'd0 : rd;
            wr      = req_we && !bad && (req_wstrb != 8'h0);
            if (wr && hs && req_wstrb[0]) m_msip = req_wdata[0];
            if (wr && hc) m_cmp = apply_strobes(m_cmp, req_wdata, req_wstrb);
            if (wr && ht) begin
                nt     = apply_strobes(m_mtime, req_wdata, req_wstrb);
                m_twen = 1'b1;
            end
        end else if (resp_ready) begin
            m_rv = 1'b0;
        end
        m_mtime = nt;
        if (m_twen) m_twdata = nt;
        m_cyc++;

        @(posedge clock);
        #1;
        check("resp_valid", 64'(resp_valid), 64'(m_rv));
        if (m_rv) begin
            check("resp_rdata", resp_rdata, m_rdata);
            check("resp_err", 64'(resp_err), 64'(m_err));
        end
        check("time_w_en", 64'(time_w_en), 64'(m_twen));
        if (m_twen) check("time_w_data", time_w_data, m_twdata);
        check("mip_mtip", 64'(mip_mtip), 64'(m_mtip));
        check("mip_stip", 64'(mip_stip), 64'(m_stip));
        check("mip_msip", 64'(mip_msip), 64'(m_msip_o));
    endtask

    task automatic issue(input logic we, input logic [15:0] addr, input logic [63:0] data,
                         input logic [7:0] strb);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        step();
        set_idle();
    endtask

    initial begin
        int          pulses;
        logic        rose;
        logic [63:0] held_rdata;

        set_idle();
        resp_ready     = 1'b1;
        stimecmp_rdata = '1;
        menvcfg_rdata  = '0;
        do_reset();

        // Idle prescaler run: three pulses carrying 1, 2, 3
        pulses = 0;
        for (int i = 0; i < 3 * TD; i++) begin
            step();
            if (time_w_en) pulses++;
        end
        check("tick_pulses", 64'(pulses), 64'd3);
        issue(1'b0, 16'hBFF8, 64'd0, 8'h00);
        check("mtime_after_idle", resp_rdata, 64'd3);

        // mtimecmp compare and release
        issue(1'b1, 16'h4000, 64'd5, 8'hFF);
        rose = 1'b0;
        for (int i = 0; i < 40 && !rose; i++) begin
            step();
            rose = mip_mtip;
        end
        check("mtip_rose", 64'(rose), 64'd1);
        issue(1'b1, 16'h4000, '1, 8'hFF);
        check("mtip_hold_one_edge", 64'(mip_mtip), 64'd1);
        step();
        check("mtip_fell", 64'(mip_mtip), 64'd0);

        // mtime write colliding with a tick
        issue(1'b1, 16'hBFF8, 64'h1_0000_0007, 8'hFF);
        for (int i = 0; i < TD && (m_cyc % TD) != TD - 1; i++) step();
        issue(1'b1, 16'hBFF8, 64'hDEAD_BEEF, 8'h0F);
        check("collide_twen", 64'(time_w_en), 64'd1);
        check("collide_twdata", time_w_data, 64'h1_DEAD_BEEF);
        issue(1'b0, 16'hBFF8, 64'd0, 8'h00);
        check("collide_mtime", resp_rdata, 64'h1_DEAD_BEEF);

        // Sstc: STCE gating
        stimecmp_rdata = 64'd0;
        menvcfg_rdata  = 64'd0;
        step();
        check("stip_stce_off", 64'(mip_stip), 64'd0);
        menvcfg_rdata = 64'h8000_0000_0000_0000;
        step();
        check("stip_stce_on", 64'(mip_stip), 64'd1);

        // msip and faults
        issue(1'b1, 16'h0000, 64'hFFFF_FFFF, 8'hFF);
        step();
        check("msip_pending", 64'(mip_msip), 64'd1);
        issue(1'b0, 16'h0000, 64'd0, 8'h00);
        check("msip_read", resp_rdata, 64'd1);
        issue(1'b0, 16'h0004, 64'd0, 8'h00);
        check("misaligned_err", 64'(resp_err), 64'd1);
        check("misaligned_rdata", resp_rdata, 64'd0);
        issue(1'b0, 16'h1000, 64'd0, 8'h00);
        check("unmapped_err", 64'(resp_err), 64'd1);
        check("unmapped_rdata", resp_rdata, 64'd0);

        // Backpressure: response holds, no second accept, then release
        resp_ready = 1'b0;
        issue(1'b0, 16'h4000, 64'd0, 8'h00);
        held_rdata = resp_rdata;
        req_valid  = 1'b1;
        req_addr   = 16'hBFF8;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rdata_stable", resp_rdata, held_rdata);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        step();
        set_idle();
        step();

        // Reset with a response outstanding drops it asynchronously
        resp_ready = 1'b0;
        issue(1'b0, 16'hBFF8, 64'd0, 8'h00);
        #3;
        do_reset();
        resp_ready = 1'b1;
        repeat (3) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
                0:       req_addr = 16'h0000;
                1:       req_addr = 16'h4000;
                2:       req_addr = 16'hBFF8;
                3:       req_addr = 16'h4000 | 16'($urandom_range(1, 7));
                4:       req_addr = 16'($urandom());
                default: req_addr = 16'hBFF8;
            endcase
            case ($urandom_range(0, 2))
                0:       req_wdata = m_mtime + 64'($urandom_range(0, 12));
                1:       req_wdata = rand64();
                default: req_wdata = 64'($urandom_range(0, 3));
            endcase
            req_wstrb  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            resp_ready = ($urandom_range(0, 3) != 0);
            stimecmp_rdata = $urandom_range(0, 1) ? m_mtime + 64'($urandom_range(0, 4)) - 64'd2 : rand64();
            menvcfg_rdata  = {$urandom_range(0, 1) == 1, 63'(rand64())};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
